// File: rtl/lcd_line_scheduler.sv
// Frames one memory-LCD multi-line write: SCS setup, command, per-line {addr, data, dummy}, final dummy, SCS hold.
// Pixel bytes are popped from a FWFT FIFO only on accepted data beats; an empty FIFO stalls the frame.
module lcd_line_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_BYTES  = 50,
  parameter int NUM_LINES   = 240,
  parameter int LADDR_WIDTH = 8,
  parameter int SCS_SETUP   = 4,
  parameter int SCS_HOLD    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_vcom,
  input  logic                  i_rempty,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rinc,
  output logic                  o_tx_valid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_scs,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic                  o_frame_done
);

  localparam int TMAX = (SCS_SETUP > SCS_HOLD) ? SCS_SETUP : SCS_HOLD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BCW  = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DATA, LTRAIL, FTRAIL, HOLD
  } state_e;

  state_e                 state_q;
  logic                   vcom_q;
  logic [TW-1:0]          tmr_q;
  logic [BCW-1:0]         bcnt_q;
  logic [LADDR_WIDTH-1:0] line_q;
  logic                   scs_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   beat;

  assign beat = o_tx_valid & i_tx_ready;

  // Counters reload on state entry, so none of them ever needs to wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      vcom_q  <= 1'b0;
      tmr_q   <= '0;
      bcnt_q  <= '0;
      line_q  <= '0;
      scs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= SETUP;
            vcom_q  <= i_vcom;
            tmr_q   <= TW'(SCS_SETUP - 1);
            scs_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (tmr_q == '0) state_q <= CMD;
          else             tmr_q   <= tmr_q - TW'(1);
        end
        CMD: begin
          if (beat) begin
            line_q  <= LADDR_WIDTH'(1);
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (beat) begin
            bcnt_q  <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (bcnt_q == BCW'(LINE_BYTES - 1)) state_q <= LTRAIL;
            else                                 bcnt_q  <= bcnt_q + BCW'(1);
          end
        end
        LTRAIL: begin
          if (beat) begin
            if (line_q == LADDR_WIDTH'(NUM_LINES)) begin
              state_q <= FTRAIL;
            end else begin
              line_q  <= line_q + LADDR_WIDTH'(1);
              state_q <= ADDR;
            end
          end
        end
        FTRAIL: begin
          if (beat) begin
            tmr_q   <= TW'(SCS_HOLD - 1);
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tmr_q == '0) begin
            state_q <= IDLE;
            scs_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      CMD: begin
        o_tx_valid = 1'b1;
        o_tx_data  = {1'b1, vcom_q, 6'b0};
      end
      ADDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = DATA_WIDTH'(line_q);
      end
      DATA: begin
        o_tx_valid = ~i_rempty;
        o_tx_data  = i_rdata;
      end
      LTRAIL, FTRAIL: o_tx_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_rinc       = (state_q == DATA) & o_tx_valid & i_tx_ready;
  assign o_stall      = (state_q == DATA) & i_rempty;
  assign o_scs        = scs_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Directed bench for lcd_line_scheduler: 2 lines x 3 bytes, 2-cycle SCS setup/hold, FWFT FIFO model.
module tb_lcd_line_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_vcom;
  logic       i_rempty;
  logic [7:0] i_rdata;
  logic       o_rinc;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready;
  logic       o_scs;
  logic       o_busy;
  logic       o_stall;
  logic       o_frame_done;

  lcd_line_scheduler #(
    .DATA_WIDTH(8), .LINE_BYTES(3), .NUM_LINES(2),
    .LADDR_WIDTH(8), .SCS_SETUP(2), .SCS_HOLD(2)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_vcom(i_vcom),
    .i_rempty(i_rempty), .i_rdata(i_rdata), .o_rinc(o_rinc),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_scs(o_scs), .o_busy(o_busy), .o_stall(o_stall), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int         nvec = 0;
  int         nerr = 0;
  int         cyc = 0;
  logic [7:0] fifo[$];
  logic [7:0] got[$];
  int         pops, ndone, done_cyc, scs_first, scs_last, nstall, nbad;
  bit         scs_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    i_rempty = (fifo.size() == 0);
    i_rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic load_fifo(input int first, input int last);
    for (int v = first; v <= last; v++) fifo.push_back(8'(v));
    drive_fifo();
  endtask

  task automatic reset_mon();
    got.delete();
    pops = 0; ndone = 0; done_cyc = -1; scs_first = -1; scs_last = -1;
    nstall = 0; nbad = 0; scs_seen = 0;
  endtask

  // Observe the current cycle just before its closing edge, then advance one cycle.
  task automatic tick();
    bit do_pop;
    #1;
    do_pop = 0;
    if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
    if (o_rinc) begin pops++; do_pop = 1; end
    if (o_frame_done) begin ndone++; done_cyc = cyc; end
    if (o_scs) begin
      if (!scs_seen) scs_first = cyc;
      scs_seen = 1;
      scs_last = cyc;
    end
    if (o_stall) begin
      nstall++;
      if (o_tx_valid || o_rinc) nbad++;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (do_pop) void'(fifo.pop_front());
    drive_fifo();
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 100 && ndone == 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic verify_frame(input string pfx, input logic [7:0] cmd);
    logic [7:0] e[12];
    e = '{cmd, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00, 8'h02, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    check({pfx, "_len"}, 32'(got.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_byte%0d", pfx, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(e[i]));
    check({pfx, "_pops"}, 32'(pops), 32'd6);
    check({pfx, "_ndone"}, 32'(ndone), 32'd1);
  endtask

  task automatic wait_pops(input string tag, input int n);
    for (int i = 0; i < 60 && pops < n; i++) tick();
    check(tag, 32'(pops), 32'(n));
  endtask

  int n0;

  initial begin
    i_rst_n = 1'b0; i_start = 1'b1; i_vcom = 1'b1; i_tx_ready = 1'b1;
    drive_fifo();
    reset_mon();

    // 1: reset holds everything low even with start asserted
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("rst_scs",  32'(o_scs), 0);
    check("rst_valid", 32'(o_tx_valid), 0);
    check("rst_rinc", 32'(o_rinc), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_frame_done), 0);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    tick();

    // 2: nominal frame
    reset_mon();
    load_fifo(1, 6);
    n0 = cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_to_done();
    verify_frame("nom", 8'hC0);
    check("nom_scs_first", 32'(scs_first), 32'(n0 + 1));
    check("nom_scs_last",  32'(scs_last),  32'(n0 + 16));
    check("nom_done_cyc",  32'(done_cyc),  32'(n0 + 17));
    check("nom_stall", 32'(nstall), 0);

    // 3: FIFO underrun after byte 02 for 5 cycles
    reset_mon();
    load_fifo(1, 2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_pops("ur_wait", 2);
    for (int i = 0; i < 5; i++) tick();
    check("ur_stall_cycles", 32'(nstall), 5);
    check("ur_valid_or_rinc_in_stall", 32'(nbad), 0);
    load_fifo(3, 6);
    run_to_done();
    verify_frame("ur", 8'hC0);
    check("ur_stall_total", 32'(nstall), 5);

    // 4: backpressure while line address 02 is offered
    reset_mon();
    load_fifo(1, 6);
    n0 = cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (pops == 3 && o_tx_valid && o_tx_data == 8'h02) break;
      tick();
    end
    check("bp_found", {23'd0, o_tx_valid, o_tx_data}, 32'h102);
    i_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_hold%0d", i), {23'd0, o_tx_valid, o_tx_data}, 32'h102);
      check($sformatf("bp_rinc%0d", i), 32'(o_rinc), 0);
      tick();
    end
    i_tx_ready = 1'b1;
    run_to_done();
    verify_frame("bp", 8'hC0);
    check("bp_scs_last", 32'(scs_last), 32'(n0 + 19));
    check("bp_done_cyc", 32'(done_cyc), 32'(n0 + 20));

    // 5: reset mid-DATA, then a clean frame
    reset_mon();
    load_fifo(1, 6);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_pops("mr_wait", 2);
    i_rst_n = 1'b0;
    #1;
    check("mr_scs_async", 32'(o_scs), 0);
    tick();
    check("mr_scs",   32'(o_scs), 0);
    check("mr_busy",  32'(o_busy), 0);
    check("mr_valid", 32'(o_tx_valid), 0);
    i_rst_n = 1'b1;
    fifo.delete();
    reset_mon();
    load_fifo(1, 6);
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_to_done();
    verify_frame("mr", 8'hC0);

    // 6: vcom=0 frame with extra start pulses while busy
    reset_mon();
    load_fifo(1, 6);
    i_vcom = 1'b0;
    i_start = 1'b1;
    tick();
    i_vcom = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_start = i[0];
      tick();
    end
    i_start = 1'b0;
    run_to_done();
    for (int i = 0; i < 20; i++) tick();
    verify_frame("v0", 8'h80);
    check("v0_busy_after", 32'(o_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
